// File: rtl/nco_pkg.sv
// Shared widths, quadrant encoding and pipeline depth for the quadrature NCO.
package nco_pkg;

    localparam int unsigned PHASE_W_DEF = 32;
    localparam int unsigned LUT_AW_DEF  = 10;
    localparam int unsigned OUT_W_DEF   = 13;
    localparam int unsigned LATENCY     = 3;

    typedef enum logic [1:0] {
        Quad0 = 2'd0,
        Quad1 = 2'd1,
        Quad2 = 2'd2,
        Quad3 = 2'd3
    } quad_e;

    // Cosine leads sine by exactly one quadrant.
    localparam logic [1:0] COS_QUAD_STEP = 2'd1;

    function automatic int unsigned amplitude(int unsigned out_w);
        return (32'd1 << (out_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// Quarter-wave sine ROM with half-sample offset, two registered read ports.
module nco_qw_rom
    import nco_pkg::*;
#(
    parameter int unsigned LUT_AW = LUT_AW_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [LUT_AW-3:0] addr_sin,
    input  logic [LUT_AW-3:0] addr_cos,
    output logic [OUT_W-2:0]  data_sin,
    output logic [OUT_W-2:0]  data_cos
);

    localparam int unsigned N    = 1 << (LUT_AW - 2);
    localparam longint      ONE_Q = 64'sd1 << 30;
    localparam longint      PI_Q  = 64'sd3373259426;

    // round(A * sin(pi/2 * (k + 0.5) / N)) via a Q30 Taylor series.
    function automatic logic [OUT_W-2:0] qw_sample(int unsigned k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (PI_Q * longint'(2 * k + 1)) / longint'(4 * N);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        return (OUT_W - 1)'((longint'(amplitude(OUT_W)) * sum + (ONE_Q >>> 1)) >>> 30);
    endfunction

    logic [OUT_W-2:0] rom_tab [N];

    for (genvar i = 0; i < N; i++) begin : g_tab
        localparam logic [OUT_W-2:0] Val = qw_sample(i);
        assign rom_tab[i] = Val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_sin <= '0;
            data_cos <= '0;
        end else if (en) begin
            data_sin <= rom_tab[addr_sin];
            data_cos <= rom_tab[addr_cos];
        end
    end

endmodule

// File: rtl/nco_quad_gen.sv
// Quadrature NCO: phase accumulator, offset add, quarter-wave lookup with
// symmetry folding, sign stage and a 3-deep valid pipe.
module nco_quad_gen
    import nco_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned LUT_AW  = LUT_AW_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter bit          COS_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    input  logic [PHASE_W-1:0] phi_inc_i,
    input  logic               phi_inc_wr,
    input  logic [PHASE_W-1:0] phs_off_i,
    input  logic               sync_clr_i,
    output logic [OUT_W-1:0]   fsin_o,
    output logic [OUT_W-1:0]   fcos_o,
    output logic               out_valid
);

    localparam int unsigned KW = LUT_AW - 2;

    logic [PHASE_W-1:0] inc_q;
    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W-1:0] ph_full;
    logic [LUT_AW-1:0]  ph_q;
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic               unused_ph_lo;

    quad_e              quad_sin;
    quad_e              quad_cos;
    logic [KW-1:0]      k;
    logic [KW-1:0]      addr_sin;
    logic [KW-1:0]      addr_cos;
    logic               neg_sin_q;
    logic               neg_cos_q;
    logic [OUT_W-2:0]   mag_sin;
    logic [OUT_W-2:0]   mag_cos;

    assign ph_full      = acc_q + phs_off_i;
    assign unused_ph_lo = ^ph_full[PHASE_W-LUT_AW-1:0];
    assign vld_d        = {vld_q[LATENCY-2:0], 1'b1};

    // Quadrants 1 and 3 read the table mirrored; 2 and 3 are negated.
    always_comb begin
        quad_sin = quad_e'(ph_q[LUT_AW-1 -: 2]);
        quad_cos = quad_e'(ph_q[LUT_AW-1 -: 2] + COS_QUAD_STEP);
        k        = ph_q[KW-1:0];
        addr_sin = (quad_sin inside {Quad1, Quad3}) ? ~k : k;
        addr_cos = (quad_cos inside {Quad1, Quad3}) ? ~k : k;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inc_q     <= '0;
            acc_q     <= '0;
            ph_q      <= '0;
            neg_sin_q <= 1'b0;
            neg_cos_q <= 1'b0;
            vld_q     <= '0;
            fsin_o    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (phi_inc_wr) begin
                inc_q <= phi_inc_i;
            end
            if (clken) begin
                acc_q     <= sync_clr_i ? '0 : acc_q + inc_q;
                ph_q      <= ph_full[PHASE_W-1 -: LUT_AW];
                neg_sin_q <= quad_sin inside {Quad2, Quad3};
                neg_cos_q <= quad_cos inside {Quad2, Quad3};
                vld_q     <= vld_d;
                fsin_o    <= neg_sin_q ? -{1'b0, mag_sin} : {1'b0, mag_sin};
                out_valid <= &vld_d;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    nco_qw_rom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_rom (
        .clk      (clk),
        .reset    (reset),
        .en       (clken),
        .addr_sin (addr_sin),
        .addr_cos (addr_cos),
        .data_sin (mag_sin),
        .data_cos (mag_cos)
    );

    if (COS_EN) begin : g_cos
        logic [OUT_W-1:0] fcos_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                fcos_q <= '0;
            end else if (clken) begin
                fcos_q <= neg_cos_q ? -{1'b0, mag_cos} : {1'b0, mag_cos};
            end
        end
        assign fcos_o = fcos_q;
    end else begin : g_no_cos
        assign fcos_o = '0;
    end

endmodule

// File: tb/tb_nco_quad_gen.sv
// Randomised bench for nco_quad_gen against a sample-queue reference model.
module tb_nco_quad_gen;

    localparam int  A   = 4095;
    localparam real PI  = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clken = 1'b0;
    logic [31:0]        phi_inc_i = '0;
    logic               phi_inc_wr = 1'b0;
    logic [31:0]        phs_off_i = '0;
    logic               sync_clr_i = 1'b0;
    logic signed [12:0] fsin_o;
    logic signed [12:0] fcos_o;
    logic               out_valid;

    always #5 clk = ~clk;

    nco_quad_gen #(
        .PHASE_W (32),
        .LUT_AW  (10),
        .OUT_W   (13),
        .COS_EN  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clken      (clken),
        .phi_inc_i  (phi_inc_i),
        .phi_inc_wr (phi_inc_wr),
        .phs_off_i  (phs_off_i),
        .sync_clr_i (sync_clr_i),
        .fsin_o     (fsin_o),
        .fcos_o     (fcos_o),
        .out_valid  (out_valid)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(string tag, longint got, longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phases captured per enabled edge, emerge two enabled edges later.
    logic [31:0] m_acc = '0;
    logic [31:0] m_inc = '0;
    logic [31:0] m_phq [$];
    int          m_s = 0;
    int          m_c = 0;
    bit          m_v = 1'b0;
    bit          m_known = 1'b0;

    int QS [4] = '{13, 4095, -13, -4095};
    int QC [4] = '{4095, -13, -4095, 13};

    function automatic int ref_sample(logic [31:0] ph, bit cos_sel);
        int  j;
        real ang;
        real v;
        j   = int'(ph[31:22]);
        ang = 2.0 * PI * (real'(j) + 0.5) / 1024.0;
        v   = real'(A) * (cos_sel ? $cos(ang) : $sin(ang));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    task automatic step(bit rst, bit en, bit wr, logic [31:0] inc, logic [31:0] off, bit clr);
        logic [31:0] ph;
        reset      = rst;
        clken      = en;
        phi_inc_wr = wr;
        phi_inc_i  = inc;
        phs_off_i  = off;
        sync_clr_i = clr;
        @(posedge clk);
        if (rst) begin
            m_acc = '0;
            m_inc = '0;
            m_phq.delete();
            m_s = 0;
            m_c = 0;
            m_v = 1'b0;
            m_known = 1'b1;
        end else begin
            if (en) begin
                m_phq.push_back(m_acc + off);
                m_acc = clr ? 32'd0 : m_acc + m_inc;
                if (m_phq.size() == 3) begin
                    ph = m_phq.pop_front();
                    m_s = ref_sample(ph, 1'b0);
                    m_c = ref_sample(ph, 1'b1);
                    m_v = 1'b1;
                    m_known = 1'b1;
                end else begin
                    m_v = 1'b0;
                    m_known = 1'b0;
                end
            end else begin
                m_v = 1'b0;
            end
            if (wr) m_inc = inc;
        end
        #1;
        check("valid", longint'(out_valid), longint'(m_v));
        if (m_known) begin
            check("sin", longint'(fsin_o), longint'(m_s));
            check("cos", longint'(fcos_o), longint'(m_c));
        end
    endtask

    // Runs enabled edges until n valid samples, comparing against the quadrature table.
    task automatic run_expect(string tag, int n, int start, logic [31:0] off, output int first);
        int got = 0;
        int edges = 0;
        first = -1;
        for (int cyc = 0; cyc < 4 * n + 10 && got < n; cyc++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, off, 1'b0);
            edges++;
            if (out_valid) begin
                if (first < 0) first = edges;
                check({tag, "_sin"}, longint'(fsin_o), longint'(QS[(start + got) % 4]));
                check({tag, "_cos"}, longint'(fcos_o), longint'(QC[(start + got) % 4]));
                got++;
            end
        end
        check({tag, "_count"}, got, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int          first;
        int          got;
        int          s_hist [4];
        int          viol_amp;
        int          viol_pow;
        int          crossings;
        int          prev_s;
        longint      pw;
        real         exp_cycles;
        logic [31:0] cur_inc;
        logic [31:0] cur_off;

        // Reset and plain quadrature at quarter-turn steps.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_sin", longint'(fsin_o), 0);
        step(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'd0, 1'b0);
        run_expect("quad", 8, 0, 32'd0, first);
        check("latency", first, 3);

        // Clear mid-stream: two old samples, then phase 0 again.
        step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
            if (out_valid) begin
                s_hist[got] = int'(fsin_o);
                got++;
            end
        end
        check("clr_count", got, 4);
        check("clr_restart0", s_hist[2], 13);
        check("clr_restart1", s_hist[3], 4095);

        // Increment reload to an eighth turn, then stalls.
        step(1'b0, 1'b1, 1'b1, 32'h2000_0000, 32'd0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, (i % 3) != 1, 1'b0, 32'd0, 32'd0, 1'b0);

        // Half-turn offset from a fresh start.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h8000_0000, 1'b0);
        run_expect("offset", 8, 2, 32'h8000_0000, first);
        check("offset_latency", first, 3);

        // Long run at an irrational-ish step: amplitude, power and period.
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h19A0_2752, 32'd0, 1'b0);
        got = 0;
        viol_amp = 0;
        viol_pow = 0;
        crossings = 0;
        prev_s = 0;
        for (int cyc = 0; cyc < 4200 && got < 4096; cyc++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
            if (out_valid) begin
                if (fsin_o > 13'sd4095 || fsin_o < -13'sd4095) viol_amp++;
                pw = longint'(fsin_o) * longint'(fsin_o) + longint'(fcos_o) * longint'(fcos_o);
                if (pw < 64'd16601334 || pw > 64'd16936715) viol_pow++;
                if (got > 0 && prev_s < 0 && int'(fsin_o) >= 0) crossings++;
                prev_s = int'(fsin_o);
                got++;
            end
        end
        exp_cycles = 4096.0 * real'(32'h19A0_2752) / 4294967296.0;
        check("circle_count", got, 4096);
        check("circle_amp", viol_amp, 0);
        check("circle_pow", viol_pow, 0);
        check("circle_period", (($rtoi(exp_cycles) - crossings) <= 2 &&
                                (crossings - $rtoi(exp_cycles)) <= 2) ? 1 : 0, 1);

        // Random enables, reloads, offsets, clears and occasional resets.
        cur_inc = $urandom();
        cur_off = '0;
        step(1'b0, 1'b1, 1'b1, cur_inc, cur_off, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit wr;
            bit clr;
            bit rst;
            en  = ($urandom_range(0, 2) != 0);
            wr  = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 499) == 0) || (i == 1500);
            if (wr) cur_inc = $urandom();
            if ($urandom_range(0, 99) == 0) cur_off = $urandom();
            step(rst, en, wr, cur_inc, cur_off, clr);
            if (rst) begin
                check("mid_rst_sin", longint'(fsin_o), 0);
                check("mid_rst_cos", longint'(fcos_o), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nco_quad_gen.md
Name: nco_quad_gen

Overview:
Parametrised quadrature numerically controlled oscillator, the successor to the fixed 32-bit/13-bit sine-only NCO. It generates signed sine and cosine samples from a phase accumulator, using a quarter-wave ROM with half-sample symmetry. It adds runtime increment reload, a phase offset and synchronous phase clear. It feeds the ADC test and demodulation path as the local oscillator.

Parameters:
PHASE_W, 32, phase accumulator / increment / offset width
LUT_AW, 10, phase bits used for lookup; quarter ROM depth N = 2^(LUT_AW-2)
OUT_W, 13, signed output sample width; amplitude A = 2^(OUT_W-1)-1
COS_EN, 1, 1 = drive fcos_o; 0 = fcos_o tied 0 and cosine path removed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clken  in  1  clock enable; accumulator and pipeline advance only when 1
phi_inc_i  in  PHASE_W  phase increment (unsigned, modulo 2^PHASE_W)
phi_inc_wr  in  1  load strobe for phi_inc_i
phs_off_i  in  PHASE_W  phase offset added after the accumulator (sampled every enabled cycle)
sync_clr_i  in  1  clear the accumulator to 0
fsin_o  out  OUT_W  signed sine sample
fcos_o  out  OUT_W  signed cosine sample
out_valid  out  1  fsin_o/fcos_o hold a new sample this cycle

Behaviour:
- Reset (one clk edge with reset=1): acc=0, inc_reg=0, all pipeline registers=0, valid pipe=0, fsin_o=0, fcos_o=0, out_valid=0. This wins over all other inputs.
- inc_reg: loads phi_inc_i on any edge with phi_inc_wr=1, independent of clken. Until the first load the NCO outputs a constant phase-0 sample.
- Accumulator, edges with clken=1:
  - sync_clr_i=1 -> acc <= 0 (priority over accumulation).
  - Otherwise acc <= acc + inc_reg, wrapping mod 2^PHASE_W.
  - A phi_inc_wr on the same edge does not affect this add; the new increment is used from the next edge.
- Stage 1 (clken=1): ph <= acc + phs_off_i mod 2^PHASE_W. Uses pre-update acc, so the first sample after reset or clear has phase = offset. Lookup phase = ph[PHASE_W-1 -: LUT_AW], truncated, no dither. q = top 2 bits; k = next LUT_AW-2 bits.
- Stage 2 (clken=1): ROM read.
  - ROM[k] = round(A*sin(pi/2*(k+0.5)/N)), unsigned OUT_W-1 bits.
  - sine address: k for q in {0,2}, ~k for q in {1,3}; negate flag = q[1].
  - cosine uses qc = q+1 (mod 4) with the same rules.
- Stage 3 (clken=1): apply two's-complement negation and register fsin_o/fcos_o. Output range is exactly [-A, +A]; no -2^(OUT_W-1) code.
- Latency: a sample captured in stage 1 at enabled edge E1 appears on the outputs after the third enabled edge (E3). Valid pipe is a 3-bit shift register shifting in 1 on each enabled edge.
- out_valid: registered. On an enabled edge = valid pipe full. On an edge with clken=0, out_valid <= 0 while fsin_o/fcos_o hold their value.
- clken low stalls everything except inc_reg loads; no samples are lost or duplicated.
- sync_clr_i does not flush the pipeline; up to 2 pre-clear samples still emerge, then phase 0 + offset.
- Reset mid-operation: outputs return to 0 and out_valid to 0 on the reset edge; after release, out_valid rises after 3 enabled edges.

Decomposition:
- Package nco_pkg: default widths, amplitude function A(OUT_W), quadrant encoding constants, LATENCY=3.
- Sub-module nco_qw_rom (params LUT_AW, OUT_W): synchronous quarter-wave ROM with dual read ports (sine/cosine), initialised by a constant function. The top level holds the accumulator, symmetry logic, sign stage and valid pipe.

Test Plan:
- Defaults; reset 7 cycles; phi_inc_wr with 2^30; clken=1 -> out_valid on 3rd edge after release. fsin_o: 13, 4095, -13, -4095 repeating. fcos_o: 4095, -13, -4095, 13.
- phi_inc 0x19A02752 for 4096 samples -> |fsin_o| <= 4095; fsin^2+fcos^2 within 4095^2 +/- 1%; period consistent with inc/2^32.
- phs_off_i=2^31 with inc 2^30 -> fsin_o sequence -13, -4095, 13, 4095.
- clken toggled 1/0 pseudo-randomly -> out_valid only on enabled cycles; the valid-sample stream equals the clken=1 reference stream.
- sync_clr_i pulse mid-stream -> 2 old samples, then 13 (phase 0) restarts the sequence; phi_inc_wr to 2^29 at edge E -> step changes from edge E+1.
- reset asserted mid-stream -> all outputs 0 next edge; out_valid=0 until 3 enabled edges after release.
